// File: rtl/fir_sym_serial_if.sv
// Bus bundle for the serial symmetric FIR: sample stream in, coefficient
// write port, and the filtered result strobe. The filter is the slave; the
// producer/consumer side is the master.
interface fir_sym_serial_if #(
    parameter int DW = 8,
    parameter int CW = 13,
    parameter int OW = 16,
    parameter int AW = 6
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic signed [CW-1:0] coef_data;
    logic                 coef_ready;
    logic                 out_valid;
    logic signed [OW-1:0] out_data;
    logic                 out_sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_data,
        input  in_ready, coef_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_data,
        output in_ready, coef_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_sym_serial.sv
// Serial symmetric FIR. Samples live in a circular buffer addressed by a
// wrapping write pointer; each output is built by one pre-adder and one
// multiplier that walk the folded coefficient set one index per cycle.
// Sequence per sample: IDLE (accept) -> MAC (H cycles) -> OUT (round and
// saturate into the output registers), so the result strobe rises H+1 edges
// after the accept edge and a new sample can be taken every H+2 cycles.
module fir_sym_serial #(
    parameter int DW     = 8,
    parameter int CW     = 13,
    parameter int NTAPS  = 91,
    parameter int OSHIFT = 12,
    parameter int OW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fir_sym_serial_if.slave bus
);
    localparam int H     = (NTAPS + 1) / 2;
    localparam int AW    = (H > 1) ? $clog2(H) : 1;
    localparam int PW    = $clog2(NTAPS);
    localparam int PREW  = DW + 1;
    localparam int PRODW = DW + CW + 1;
    localparam int ACCW  = PRODW + $clog2(H);
    // one guard bit so adding the rounding constant can never wrap
    localparam int RW    = ACCW + 1;
    localparam int HSH   = (OSHIFT > 0) ? (OSHIFT - 1) : 0;

    localparam logic signed [RW-1:0] HALF    = (OSHIFT > 0) ? RW'(64'sd1 <<< HSH) : RW'(64'sd0);
    localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (OW - 1)) - 64'sd1);
    localparam logic signed [RW-1:0] SAT_MIN = RW'(-(64'sd1 <<< (OW - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                state_r;
    logic signed [DW-1:0]  samp_r [NTAPS];
    logic signed [CW-1:0]  coef_r [H];
    logic [PW-1:0]         wptr_r;
    logic [PW-1:0]         rda_r;
    logic [PW-1:0]         rdb_r;
    logic [AW-1:0]         k_r;
    logic signed [ACCW-1:0] acc_r;
    logic                  in_ready_r;
    logic                  coef_ready_r;
    logic                  out_valid_r;
    logic signed [OW-1:0]  out_data_r;
    logic                  out_sat_r;

    logic signed [DW-1:0]    tap_a_s;
    logic signed [DW-1:0]    tap_b_s;
    logic signed [PREW-1:0]  pre_s;
    logic signed [PRODW-1:0] prod_s;
    logic                    coef_wr_s;

    // Circular pointer step forward, wrapping at NTAPS
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(NTAPS - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Circular pointer step backward, wrapping at 0
    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        if (p == '0) begin
            return PW'(NTAPS - 1);
        end else begin
            return p - PW'(1);
        end
    endfunction

    // Round half up, arithmetic shift, clip to OW bits; MSB of result is the clip flag
    function automatic logic [OW:0] round_sat(input logic signed [ACCW-1:0] a);
        logic signed [RW-1:0] ext;
        logic signed [RW-1:0] rnd;
        ext = RW'(a);
        if (OSHIFT > 0) begin
            rnd = (ext + HALF) >>> OSHIFT;
        end else begin
            rnd = ext;
        end
        if (rnd > SAT_MAX) begin
            return {1'b1, SAT_MAX[OW-1:0]};
        end else if (rnd < SAT_MIN) begin
            return {1'b1, SAT_MIN[OW-1:0]};
        end else begin
            return {1'b0, rnd[OW-1:0]};
        end
    endfunction

    // Coefficient writes land only while the port is open and the index is in range
    assign coef_wr_s = coef_ready_r & bus.coef_we & (32'(bus.coef_addr) < 32'(H));

    // Folded tap pair for index k: newest-side tap plus oldest-side tap, centre tap alone
    always_comb begin
        tap_a_s = samp_r[rda_r];
        tap_b_s = samp_r[rdb_r];
        if (k_r == AW'(H - 1)) begin
            pre_s = PREW'(tap_a_s);
        end else begin
            pre_s = PREW'(tap_a_s) + PREW'(tap_b_s);
        end
        prod_s = PRODW'(pre_s) * PRODW'(coef_r[k_r]);
    end

    // Coefficient storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < H; i++) begin
                coef_r[i] <= '0;
            end
        end else if (coef_wr_s) begin
            coef_r[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Sequencer: accept, multiply-accumulate over the folded taps, publish result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            for (int i = 0; i < NTAPS; i++) begin
                samp_r[i] <= '0;
            end
            wptr_r       <= '0;
            rda_r        <= '0;
            rdb_r        <= '0;
            k_r          <= '0;
            acc_r        <= '0;
            in_ready_r   <= 1'b1;
            coef_ready_r <= 1'b1;
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            out_sat_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        samp_r[wptr_r] <= bus.in_data;
                        wptr_r         <= ptr_inc(wptr_r);
                        // newest sample walks backwards, oldest walks forwards
                        rda_r          <= wptr_r;
                        rdb_r          <= ptr_inc(wptr_r);
                        acc_r          <= '0;
                        k_r            <= '0;
                        in_ready_r     <= 1'b0;
                        coef_ready_r   <= 1'b0;
                        state_r        <= MAC;
                    end else begin
                        in_ready_r   <= 1'b1;
                        coef_ready_r <= 1'b1;
                        state_r      <= IDLE;
                    end
                end
                MAC: begin
                    acc_r <= acc_r + ACCW'(prod_s);
                    rda_r <= ptr_dec(rda_r);
                    rdb_r <= ptr_inc(rdb_r);
                    if (k_r == AW'(H - 1)) begin
                        state_r <= OUT;
                    end else begin
                        k_r     <= k_r + AW'(1);
                        state_r <= MAC;
                    end
                end
                OUT: begin
                    {out_sat_r, out_data_r} <= round_sat(acc_r);
                    out_valid_r  <= 1'b1;
                    in_ready_r   <= 1'b1;
                    coef_ready_r <= 1'b1;
                    state_r      <= IDLE;
                end
                default: begin
                    in_ready_r   <= 1'b1;
                    coef_ready_r <= 1'b1;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.coef_ready = coef_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_sat    = out_sat_r;

endmodule

// File: tb/tb_fir_sym_serial.sv
// Bench for fir_sym_serial: three instances (5 taps, 3 taps with rounding,
// 91 taps default) driven one at a time through a shared stimulus set and
// checked against a direct-form convolution model.
module tb_fir_sym_serial;
    logic clk;
    logic rst_n;

    fir_sym_serial_if #(.DW(8), .CW(13), .OW(16), .AW(2)) b5 ();
    fir_sym_serial_if #(.DW(8), .CW(13), .OW(16), .AW(1)) b3 ();
    fir_sym_serial_if #(.DW(8), .CW(13), .OW(16), .AW(6)) b91 ();

    fir_sym_serial #(.DW(8), .CW(13), .NTAPS(5), .OSHIFT(0), .OW(16))
        u5 (.clk(clk), .rst_n(rst_n), .bus(b5.slave));
    fir_sym_serial #(.DW(8), .CW(13), .NTAPS(3), .OSHIFT(1), .OW(16))
        u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));
    fir_sym_serial #(.DW(8), .CW(13), .NTAPS(91), .OSHIFT(0), .OW(16))
        u91 (.clk(clk), .rst_n(rst_n), .bus(b91.slave));

    int                 sel;
    logic               tv;
    logic               tw;
    logic signed [7:0]  tdin;
    logic [5:0]         taddr;
    logic signed [12:0] tcd;

    logic               o_ready;
    logic               o_cready;
    logic               o_valid;
    logic signed [15:0] o_data;
    logic               o_sat;

    int n_cmp;
    int n_bad;

    // model state for the instance currently selected
    int     m_nt;
    int     m_h;
    int     m_osh;
    longint hist_m [0:90];
    longint coef_m [0:45];

    assign b5.in_valid   = (sel == 0) ? tv : 1'b0;
    assign b5.in_data    = tdin;
    assign b5.coef_we    = (sel == 0) ? tw : 1'b0;
    assign b5.coef_addr  = taddr[1:0];
    assign b5.coef_data  = tcd;
    assign b3.in_valid   = (sel == 1) ? tv : 1'b0;
    assign b3.in_data    = tdin;
    assign b3.coef_we    = (sel == 1) ? tw : 1'b0;
    assign b3.coef_addr  = taddr[0:0];
    assign b3.coef_data  = tcd;
    assign b91.in_valid  = (sel == 2) ? tv : 1'b0;
    assign b91.in_data   = tdin;
    assign b91.coef_we   = (sel == 2) ? tw : 1'b0;
    assign b91.coef_addr = taddr;
    assign b91.coef_data = tcd;

    always_comb begin
        case (sel)
            0: begin
                o_ready = b5.in_ready; o_cready = b5.coef_ready; o_valid = b5.out_valid;
                o_data = b5.out_data; o_sat = b5.out_sat;
            end
            1: begin
                o_ready = b3.in_ready; o_cready = b3.coef_ready; o_valid = b3.out_valid;
                o_data = b3.out_data; o_sat = b3.out_sat;
            end
            default: begin
                o_ready = b91.in_ready; o_cready = b91.coef_ready; o_valid = b91.out_valid;
                o_data = b91.out_data; o_sat = b91.out_sat;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic mselect(input int s, input int nt, input int osh);
        sel = s; m_nt = nt; m_h = (nt + 1) / 2; m_osh = osh;
    endtask

    task automatic mreset();
        for (int i = 0; i < 91; i++) hist_m[i] = 0;
        for (int i = 0; i < 46; i++) coef_m[i] = 0;
    endtask

    task automatic mpush(input int x);
        for (int i = 90; i > 0; i--) hist_m[i] = hist_m[i-1];
        hist_m[0] = x;
    endtask

    // y[n] = sum over all NTAPS of h[j]*x[n-j], h mirrored around the centre
    task automatic model(output longint y, output bit s);
        longint acc;
        int kk;
        acc = 0;
        for (int j = 0; j < m_nt; j++) begin
            kk = (j < m_h) ? j : (m_nt - 1 - j);
            acc += coef_m[kk] * hist_m[j];
        end
        if (m_osh > 0) acc = (acc + (longint'(1) <<< (m_osh - 1))) >>> m_osh;
        s = 1'b0;
        if (acc > 32767) begin acc = 32767; s = 1'b1; end
        else if (acc < -32768) begin acc = -32768; s = 1'b1; end
        y = acc;
    endtask

    task automatic coef_wr(input int a, input int d);
        @(negedge clk);
        n_cmp++;
        if (o_cready !== 1'b1) begin
            n_bad++;
            $display("FAIL coef_ready_idle: got %b required 1", o_cready);
        end
        tw = 1'b1; taddr = 6'(a); tcd = 13'(d);
        @(posedge clk); #1;
        tw = 1'b0;
        if (a < m_h) coef_m[a] = d;
    endtask

    // Push one sample, optionally with a same-cycle or mid-MAC coefficient write
    task automatic send(input int x, input bit same_we, input int wa, input int wd,
                        input bit mid_we, output longint y, output bit s);
        int lat, waitc;
        bit got, es;
        longint ey;
        logic signed [15:0] ed;
        @(negedge clk);
        tv = 1'b1; tdin = 8'(x);
        if (same_we) begin tw = 1'b1; taddr = 6'(wa); tcd = 13'(wd); end
        waitc = 0;
        while (o_ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
        if (o_ready !== 1'b1) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready=%b required 1", o_ready);
            tv = 1'b0; tw = 1'b0; y = 0; s = 1'b0;
            return;
        end
        if (same_we && wa < m_h) coef_m[wa] = wd;
        mpush(x);
        model(ey, es);
        @(posedge clk); #1;
        tv = 1'b0; tw = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 200) begin
            if (lat == 0) begin
                n_cmp++;
                if (o_ready !== 1'b0) begin
                    n_bad++; $display("FAIL busy_ready: in_ready=%b required 0", o_ready);
                end
            end
            if (mid_we && lat == 0) begin
                tw = 1'b1; taddr = 6'd0; tcd = 13'sd99;
                n_cmp++;
                if (o_cready !== 1'b0) begin
                    n_bad++; $display("FAIL busy_coef_ready: coef_ready=%b required 0", o_cready);
                end
            end
            if (lat == 2) tw = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (o_valid === 1'b1) got = 1'b1;
        end
        tw = 1'b0;
        n_cmp++;
        if (!got || lat != m_h + 1) begin
            n_bad++; $display("FAIL latency: got %0d cycles required %0d", lat, m_h + 1);
        end
        y = o_data; s = o_sat;
        ed = 16'(ey);
        n_cmp++;
        if (o_data !== ed || o_sat !== es) begin
            n_bad++;
            $display("FAIL result: x=%0d got %0d sat %b required %0d sat %b", x, o_data, o_sat, ed, es);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (o_valid !== 1'b0 || o_data !== ed || o_sat !== es) begin
            n_bad++;
            $display("FAIL hold: valid=%b data=%0d sat=%b required 0/%0d/%b", o_valid, o_data, o_sat, ed, es);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            sel = i; #1;
            n_cmp++;
            if (o_ready !== 1'b1 || o_cready !== 1'b1 || o_valid !== 1'b0 ||
                o_data !== 16'sd0 || o_sat !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_state: inst %0d rdy=%b crdy=%b v=%b d=%0d sat=%b required 1/1/0/0/0",
                         i, o_ready, o_cready, o_valid, o_data, o_sat);
            end
        end
    endtask

    task automatic impulse_expect(input int e0, input int e1, input int e2, input int e3, input int e4);
        int ex [5];
        longint y;
        bit s;
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
        for (int i = 0; i < 5; i++) begin
            send((i == 0) ? 1 : 0, 1'b0, 0, 0, 1'b0, y, s);
            n_cmp++;
            if (y != ex[i] || s !== 1'b0) begin
                n_bad++; $display("FAIL impulse_%0d: got %0d required %0d", i, y, ex[i]);
            end
        end
    endtask

    task automatic test_impulse();
        mselect(0, 5, 0);
        mreset();
        coef_wr(0, 1); coef_wr(1, 2); coef_wr(2, 3);
        impulse_expect(1, 2, 3, 2, 1);
    endtask

    task automatic test_coef_write();
        longint y;
        bit s;
        mselect(0, 5, 0);
        // write attempted during MAC must not reach the coefficient set
        send(1, 1'b0, 0, 0, 1'b1, y, s);
        n_cmp++;
        if (y != 1) begin n_bad++; $display("FAIL mid_mac_write: got %0d required 1", y); end
        for (int i = 0; i < 4; i++) send(0, 1'b0, 0, 0, 1'b0, y, s);
        n_cmp++;
        if (y != 1) begin n_bad++; $display("FAIL readback_tail: got %0d required 1", y); end
        // write in the accept cycle is used by that very sample
        send(5, 1'b1, 0, -7, 1'b0, y, s);
        n_cmp++;
        if (y != -35) begin n_bad++; $display("FAIL same_cycle_write: got %0d required -35", y); end
        // out-of-range index leaves everything alone
        coef_wr(3, 50);
        send(0, 1'b0, 0, 0, 1'b0, y, s);
        n_cmp++;
        if (y != 10) begin n_bad++; $display("FAIL addr_out_of_range: got %0d required 10", y); end
    endtask

    task automatic test_random(input int nsamp);
        longint y;
        bit s;
        int x;
        for (int c = 0; c < m_h; c++) coef_wr(c, int'($urandom_range(0, 8190)) - 4095);
        for (int i = 0; i < nsamp; i++) begin
            x = int'($urandom_range(0, 255)) - 128;
            if (i % 5 == 4)
                send(x, 1'b1, int'($urandom_range(0, m_h - 1)), int'($urandom_range(0, 8190)) - 4095,
                     1'b0, y, s);
            else
                send(x, 1'b0, 0, 0, 1'b0, y, s);
        end
    endtask

    task automatic test_back_to_back();
        int N, idx, last, nout, acc_now;
        int d [16];
        longint eq [$];
        bit sq [$];
        longint ey;
        bit es;
        logic signed [15:0] ed;
        mselect(0, 5, 0);
        N = 12;
        for (int i = 0; i < N; i++) d[i] = int'($urandom_range(0, 255)) - 128;
        idx = 0; last = -1; nout = 0;
        @(negedge clk);
        tv = 1'b1; tdin = 8'(d[0]);
        for (int cyc = 0; cyc < N * (m_h + 2) + 20; cyc++) begin
            if (o_valid === 1'b1) begin
                nout++;
                n_cmp++;
                if (eq.size() == 0) begin
                    n_bad++; $display("FAIL b2b_extra_output: got %0d with nothing pending", o_data);
                end else begin
                    ey = eq.pop_front(); es = sq.pop_front(); ed = 16'(ey);
                    if (o_data !== ed || o_sat !== es) begin
                        n_bad++;
                        $display("FAIL b2b_result: got %0d sat %b required %0d sat %b", o_data, o_sat, ed, es);
                    end
                end
            end
            acc_now = 0;
            if (tv && o_ready === 1'b1) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != m_h + 2) begin
                        n_bad++; $display("FAIL b2b_spacing: got %0d required %0d", cyc - last, m_h + 2);
                    end
                end
                last = cyc;
                mpush(d[idx]);
                model(ey, es);
                eq.push_back(ey); sq.push_back(es);
                idx++;
                acc_now = 1;
            end
            @(posedge clk); #1;
            if (acc_now == 1) begin
                if (idx < N) tdin = 8'(d[idx]);
                else tv = 1'b0;
            end
            @(negedge clk);
        end
        tv = 1'b0;
        n_cmp++;
        if (nout != N || idx != N) begin
            n_bad++; $display("FAIL b2b_count: accepted %0d produced %0d required %0d", idx, nout, N);
        end
    endtask

    task automatic test_rounding();
        longint y;
        bit s;
        int cs [3];
        int ex [3];
        cs[0] = 1; cs[1] = -1; cs[2] = 3;
        ex[0] = 1; ex[1] = 0;  ex[2] = 2;
        mselect(1, 3, 1);
        mreset();
        coef_wr(0, 0); coef_wr(1, 1);
        for (int i = 0; i < 3; i++) begin
            send(cs[i], 1'b0, 0, 0, 1'b0, y, s);
            send(0, 1'b0, 0, 0, 1'b0, y, s);
            n_cmp++;
            if (y != ex[i] || s !== 1'b0) begin
                n_bad++; $display("FAIL rounding_%0d: got %0d required %0d", cs[i], y, ex[i]);
            end
        end
        test_random(12);
    endtask

    task automatic test_saturation();
        longint y;
        bit s;
        mselect(2, 91, 0);
        mreset();
        for (int c = 0; c < 46; c++) coef_wr(c, 4095);
        for (int i = 0; i < 91; i++) send(127, 1'b0, 0, 0, 1'b0, y, s);
        n_cmp++;
        if (y != 32767 || s !== 1'b1) begin
            n_bad++; $display("FAIL sat_pos: got %0d sat %b required 32767 sat 1", y, s);
        end
        for (int i = 0; i < 91; i++) send(-128, 1'b0, 0, 0, 1'b0, y, s);
        n_cmp++;
        if (y != -32768 || s !== 1'b1) begin
            n_bad++; $display("FAIL sat_neg: got %0d sat %b required -32768 sat 1", y, s);
        end
    endtask

    task automatic test_reset_mid_mac();
        int waitc, seen;
        mselect(0, 5, 0);
        @(negedge clk);
        tv = 1'b1; tdin = 8'sd1;
        waitc = 0;
        while (o_ready !== 1'b1 && waitc < 100) begin @(negedge clk); waitc++; end
        @(posedge clk); #1;
        tv = 1'b0;
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        #2;
        n_cmp++;
        if (o_ready !== 1'b1 || o_cready !== 1'b1 || o_valid !== 1'b0 ||
            o_data !== 16'sd0 || o_sat !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_mac_reset_state: rdy=%b crdy=%b v=%b d=%0d sat=%b required 1/1/0/0/0",
                     o_ready, o_cready, o_valid, o_data, o_sat);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++; $display("FAIL discarded_output: got %0d strobes required 0", seen);
        end
        mreset();
        impulse_expect(0, 0, 0, 0, 0);
        coef_wr(0, 1); coef_wr(1, 2); coef_wr(2, 3);
        impulse_expect(1, 2, 3, 2, 1);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        sel = 0; tv = 1'b0; tw = 1'b0; tdin = 8'sd0; taddr = 6'd0; tcd = 13'sd0;
        m_nt = 5; m_h = 3; m_osh = 0;
        mreset();
        rst_n = 1'b0;
        #23 rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_impulse();
        test_coef_write();
        mselect(0, 5, 0);
        test_random(25);
        test_back_to_back();
        test_rounding();
        test_saturation();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fir_sym_serial.md
FIR_SYM_SERIAL -- requirements
Module: fir_sym_serial

Interface
REQ-001 SHALL have parameter DW, default 8: signed input sample width.
REQ-002 SHALL have parameter CW, default 13: signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 91: tap count, odd and >= 3; H = (NTAPS+1)/2 stored coefficients.
REQ-004 SHALL have parameter OSHIFT, default 12: accumulator right-shift applied at output.
REQ-005 SHALL have parameter OW, default 16: signed output width.
REQ-006 SHALL have port clk  input  1: single clock; all logic rising-edge.
REQ-007 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid  input  1: in_data is valid.
REQ-009 SHALL have port in_ready  output  1: block accepts a sample this cycle.
REQ-010 SHALL have port in_data  input  DW: signed sample.
REQ-011 SHALL have port coef_we  input  1: coefficient write strobe.
REQ-012 SHALL have port coef_addr  input  clog2(H): coefficient index k, 0..H-1; k=H-1 is the centre tap.
REQ-013 SHALL have port coef_data  input  CW: signed coefficient.
REQ-014 SHALL have port coef_ready  output  1: coefficient write is accepted this cycle.
REQ-015 SHALL have port out_valid  output  1: one-cycle result strobe.
REQ-016 SHALL have port out_data  output  OW: signed filtered sample.
REQ-017 SHALL have port out_sat  output  1: out_data was clipped; qualified by out_valid.

Function
REQ-018 SHALL implement symmetric FIR y[n] = sum_{k=0..H-2} c[k]*(x[n-k]+x[n-NTAPS+1+k]) + c[H-1]*x[n-H+1].
REQ-019 SHALL use one pre-adder and one multiplier, time-multiplexed, one k per cycle.
REQ-020 SHALL store the last NTAPS samples in a circular buffer with a wrapping write pointer; no data movement per sample.
REQ-021 SHALL use FSM states IDLE, MAC, OUT.
REQ-022 IDLE: in_ready=1 and coef_ready=1; on in_valid, write sample, advance pointer modulo NTAPS, clear accumulator, go to MAC with k=0.
REQ-023 MAC: in_ready=0 and coef_ready=0; add one term per cycle for k=0..H-1, then go to OUT after k=H-1.
REQ-024 OUT: out_valid=1 for exactly one cycle, in_ready=0, then return to IDLE.
REQ-025 Latency SHALL be H+1 cycles from accept edge to out_valid high; throughput SHALL be one sample per H+2 cycles.
REQ-026 Pre-adder SHALL be DW+1 bits; product SHALL be DW+CW+1 bits; accumulator SHALL be DW+CW+1+clog2(H) bits, so no internal overflow occurs.
REQ-027 out_data SHALL be (acc + 2^(OSHIFT-1)) >>> OSHIFT (round half up, arithmetic shift); with OSHIFT=0 no rounding is applied.
REQ-028 The rounded value SHALL saturate to [-2^(OW-1), 2^(OW-1)-1], and out_sat=1 when clipped.
REQ-029 coef_we SHALL write c[coef_addr] only when coef_ready=1; otherwise it is ignored, with no effect on any state.
REQ-030 When coef_we and in_valid occur in the same IDLE cycle, both SHALL take effect, and the new coefficient SHALL be used for that sample.
REQ-031 coef_addr >= H SHALL be ignored.
REQ-032 out_data and out_sat SHALL hold their last values outside out_valid.

Reset
REQ-033 rst_n low SHALL asynchronously force the following: FSM to IDLE, all sample buffer entries, coefficients and accumulator to 0, pointer and k to 0, out_valid=0, out_data=0, out_sat=0.
REQ-034 Reset asserted mid-MAC SHALL discard the computation; no out_valid follows.
REQ-035 After release, in_ready=1 and coef_ready=1 in the first cycle.

Verification
REQ-036 Impulse test: NTAPS=5, OSHIFT=0, c={1,2,3}; input 1 then four 0s -> outputs 1,2,3,2,1, each out_valid exactly 4 cycles after accept.
REQ-037 Backpressure test: hold in_valid=1 continuously -> accepts spaced H+2 cycles apart; no sample lost or duplicated; in_ready=0 during MAC and OUT.
REQ-038 Saturation test: defaults, OSHIFT=0, all c=4095, input 127 held for 91 samples -> out_data=32767 with out_sat=1; input -128 -> out_data=-32768 with out_sat=1.
REQ-039 Rounding test: NTAPS=3, OSHIFT=1, c={0,1}; centre sample 1 -> 1; centre sample -1 -> 0; centre sample 3 -> 2.
REQ-040 Coefficient write test: coef_we during MAC is ignored (readback via impulse is unchanged); a write in the IDLE cycle where a sample is accepted is used for that sample.
REQ-041 Reset test: rst_n pulsed low in MAC cycle 2 -> no out_valid; next impulse yields an all-zero response until coefficients are reloaded.
